// File: rtl/medium_activity_monitor_pkg.sv
// Shared definitions for the medium activity monitor: FSM encodings and constants.
package medium_activity_monitor_pkg;

    typedef enum logic [1:0] {
        MAM_IDLE      = 2'd0,
        MAM_SINGLE    = 2'd1,
        MAM_COLLISION = 2'd2,
        MAM_HOLD      = 2'd3
    } mam_state_e;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned HOLD_W = 8;

    // Collision is signalled both during overlap and during the stretch.
    function automatic logic is_col_state(input mam_state_e s);
        return (s == MAM_COLLISION) || (s == MAM_HOLD);
    endfunction

endpackage

// File: rtl/mam_popcount_prio.sv
// Combinational count of active nodes plus the index of the lowest active node.
module mam_popcount_prio #(
    parameter int unsigned NODES = 16,
    parameter int unsigned ID_W  = 4,
    parameter int unsigned CNT_W = 5
) (
    input  logic [NODES-1:0] act_q,
    output logic [CNT_W-1:0] n_c,
    output logic [ID_W-1:0]  idx_c
);

    // Scan high to low so the last hit is the lowest set bit.
    always_comb begin
        n_c   = '0;
        idx_c = '0;
        for (int i = int'(NODES) - 1; i >= 0; i--) begin
            n_c = n_c + CNT_W'(act_q[i]);
            if (act_q[i]) begin
                idx_c = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/medium_activity_monitor.sv
// Registered collision/carrier arbiter for the shared 10BASE-T1S mixing segment.
// Optional MEDIUM_STATS_EN adds saturating frame and collision counters.
module medium_activity_monitor
    import medium_activity_monitor_pkg::*;
#(
    parameter int unsigned NODES    = 16,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned COL_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NODES-1:0] tx_activity,
    output logic             collision,
    output logic             carrier_sense,
    output logic [ID_W-1:0]  owner_id,
    output logic             owner_valid,
    output logic             tx_done,
    output logic             handoff
`ifdef MEDIUM_STATS_EN
    ,
    output logic [15:0]      frame_count,
    output logic [15:0]      collision_count
`endif
);

    logic [NODES-1:0] act_q;
    logic [CNT_W-1:0] n_c;
    logic [ID_W-1:0]  idx_c;
    mam_state_e       state_q, state_d;
    logic [ID_W-1:0]  owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             done_d, handoff_d, enter_col_d;
    logic             n_zero, n_one, n_multi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q <= '0;
        end else begin
            act_q <= tx_activity;
        end
    end

    mam_popcount_prio #(
        .NODES (NODES),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) u_popcount (
        .act_q (act_q),
        .n_c   (n_c),
        .idx_c (idx_c)
    );

    assign n_zero  = (n_c == '0);
    assign n_one   = (n_c == CNT_W'(1));
    assign n_multi = !n_zero && !n_one;

    // Next-state, owner tracking and pulse qualification.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_id;
        hold_d      = hold_q;
        done_d      = FALSE;
        handoff_d   = FALSE;
        enter_col_d = FALSE;
        case (state_q)
            MAM_IDLE: begin
                if (n_one) begin
                    state_d = MAM_SINGLE;
                    owner_d = idx_c;
                end else if (n_multi) begin
                    state_d     = MAM_COLLISION;
                    enter_col_d = TRUE;
                end
            end
            MAM_SINGLE: begin
                if (n_zero) begin
                    state_d = MAM_IDLE;
                    done_d  = TRUE;
                end else if (n_one) begin
                    if (idx_c != owner_id) begin
                        owner_d   = idx_c;
                        handoff_d = TRUE;
                    end
                end else begin
                    state_d     = MAM_COLLISION;
                    enter_col_d = TRUE;
                end
            end
            MAM_COLLISION: begin
                if (!n_multi) begin
                    state_d = MAM_HOLD;
                    hold_d  = HOLD_W'(COL_HOLD - 1);
                end
            end
            MAM_HOLD: begin
                if (n_multi) begin
                    state_d = MAM_COLLISION;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (n_zero) begin
                    state_d = MAM_IDLE;
                end else begin
                    state_d = MAM_SINGLE;
                    owner_d = idx_c;
                end
            end
            default: state_d = MAM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= MAM_IDLE;
            hold_q        <= '0;
            owner_id      <= '0;
            collision     <= 1'b0;
            carrier_sense <= 1'b0;
            owner_valid   <= 1'b0;
            tx_done       <= 1'b0;
            handoff       <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            owner_id      <= owner_d;
            collision     <= is_col_state(state_d);
            carrier_sense <= !n_zero;
            owner_valid   <= (state_d == MAM_SINGLE);
            tx_done       <= done_d;
            handoff       <= handoff_d;
        end
    end

`ifdef MEDIUM_STATS_EN
    // Saturating event counters; HOLD->COLLISION re-entry is not a new collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count     <= '0;
            collision_count <= '0;
        end else begin
            if ((done_d || handoff_d) && (frame_count != 16'hFFFF)) begin
                frame_count <= frame_count + 16'd1;
            end
            if (enter_col_d && (collision_count != 16'hFFFF)) begin
                collision_count <= collision_count + 16'd1;
            end
        end
    end
`endif

endmodule
